snake_body_tracker: RTL and testbench

//  Owns snake state: head movement per game tick, body segment list, length, collisions.

---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_next_head.sv | 42 ++++
 rtl/snake_body_tracker.sv | 129 ++++++++++++
 tb/tb_snake_body_tracker.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game types: coordinates, directions, FSM states, sizing and reset layout.
// Also used by the apple generator.
package snake_pkg;

    localparam int unsigned CORD_W   = 8;
    localparam int unsigned MAX_LEN  = 50;
    localparam int unsigned INIT_LEN = 3;
    localparam int unsigned LEN_W    = 6;

    localparam logic [CORD_W-1:0] INIT_HEAD = 8'h55;

    typedef logic [CORD_W-1:0] cord_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_e;

    // Reset body: a horizontal line ending at the head; extra slots replicate the tail.
    function automatic cord_t init_cell(input int unsigned idx);
        int unsigned k;
        k = (idx < INIT_LEN) ? idx : INIT_LEN - 1;
        return {INIT_HEAD[7:4] - 4'(k), INIT_HEAD[3:0]};
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head cell for a move in one direction, plus wall detection.
// WRAP_WALLS_EN: coordinates wrap modulo 16 and walls are never fatal.
module snake_next_head
    import snake_pkg::*;
(
    input  cord_t head,
    input  dir_e  dir,
    output cord_t nh_c,
    output logic  wall_hit_c
);

    logic [3:0] x;
    logic [3:0] y;

    // Nibble arithmetic wraps naturally; the wall check decides whether that is legal.
    always_comb begin
        x = head[7:4];
        y = head[3:0];
        case (dir)
            UP:      y = head[3:0] - 4'd1;
            RIGHT:   x = head[7:4] + 4'd1;
            DOWN:    y = head[3:0] + 4'd1;
            default: x = head[7:4] - 4'd1;
        endcase
        nh_c = {x, y};
    end

`ifdef WRAP_WALLS_EN
    assign wall_hit_c = 1'b0;
`else
    always_comb begin
        wall_hit_c = 1'b0;
        case (dir)
            UP:      wall_hit_c = (head[3:0] == 4'h0);
            RIGHT:   wall_hit_c = (head[7:4] == 4'hF);
            DOWN:    wall_hit_c = (head[3:0] == 4'hF);
            default: wall_hit_c = (head[7:4] == 4'h0);
        endcase
    end
`endif

endmodule

// File: rtl/snake_body_tracker.sv
// Snake state owner: game FSM, direction, body shift array, length and collisions.
// Wall behaviour follows WRAP_WALLS_EN (resolved in snake_next_head).
module snake_body_tracker
    import snake_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    step,
    input  logic [1:0]              dir_req,
    input  cord_t                   apple_cord,
    output cord_t [MAX_LEN-1:0]     body,
    output logic  [LEN_W-1:0]       length,
    output logic                    goodColl,
    output logic                    badColl,
    output logic                    running
);

    state_e               state, state_n;
    dir_e                 dir, dir_n;
    dir_e                 pend, pend_n;
    dir_e                 cmp_dir;
    cord_t [MAX_LEN-1:0]  body_n;
    logic  [LEN_W-1:0]    len_n;
    logic  [LEN_W-1:0]    len_sh;
    logic                 good_n, bad_n;
    cord_t                nh;
    cord_t                tail_new;
    logic                 wall_hit;
    logic                 grow_raw;
    logic                 self_hit;

    snake_next_head u_next_head (
        .head       (body[0]),
        .dir        (pend),
        .nh_c       (nh),
        .wall_hit_c (wall_hit)
    );

    // The tail cell only leaves the body when the snake does not grow.
    always_comb begin
        grow_raw = (nh == apple_cord) && (length < LEN_W'(MAX_LEN));
        len_sh   = length + LEN_W'(grow_raw);
        self_hit = 1'b0;
        tail_new = body[0];
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((body[i] == nh) &&
                ((i < int'(length) - 1) || (grow_raw && (i == int'(length) - 1))))
                self_hit = 1'b1;
            if (i == int'(len_sh) - 2)
                tail_new = body[i];
        end
    end

    always_comb begin
        state_n = state;
        body_n  = body;
        len_n   = length;
        dir_n   = dir;
        pend_n  = pend;
        good_n  = 1'b0;
        bad_n   = 1'b0;
        // A request is legal against the direction in force after this cycle.
        cmp_dir = step ? pend : dir;
        case (state)
            IDLE: begin
                if (start)
                    state_n = RUN;
            end
            RUN: begin
                if (dir_req != 2'(cmp_dir ^ 2'd2))
                    pend_n = dir_e'(dir_req);
                if (step) begin
                    dir_n = pend;
                    if (wall_hit || self_hit) begin
                        bad_n   = 1'b1;
                        state_n = DEAD;
                    end else begin
                        good_n    = (nh == apple_cord);
                        len_n     = len_sh;
                        body_n[0] = nh;
                        for (int i = 1; i < MAX_LEN; i++)
                            body_n[i] = (i < int'(len_sh)) ? body[i-1] : tail_new;
                    end
                end
            end
            DEAD: begin
                if (start) begin
                    state_n = IDLE;
                    for (int i = 0; i < MAX_LEN; i++)
                        body_n[i] = init_cell(i);
                    len_n  = LEN_W'(INIT_LEN);
                    dir_n  = RIGHT;
                    pend_n = RIGHT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++)
                body[i] <= init_cell(i);
            length   <= LEN_W'(INIT_LEN);
            dir      <= RIGHT;
            pend     <= RIGHT;
            goodColl <= 1'b0;
            badColl  <= 1'b0;
            running  <= 1'b0;
        end else begin
            body     <= body_n;
            length   <= len_n;
            dir      <= dir_n;
            pend     <= pend_n;
            goodColl <= good_n;
            badColl  <= bad_n;
            running  <= (state_n == RUN);
        end
    end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Self-checking bench for snake_body_tracker: a table of step vectors scored through
// an expectation queue, plus hand sequences for restart, walls and reset corner cases.
module tb_snake_body_tracker;
    import snake_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                step;
    logic [1:0]          dir_req;
    cord_t               apple_cord;
    cord_t [MAX_LEN-1:0] body;
    logic  [LEN_W-1:0]   length;
    logic                goodColl;
    logic                badColl;
    logic                running;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] dir;
        cord_t      apple;
        cord_t      head;
        cord_t      tail;
        logic [5:0] len;
        logic       good;
        logic       bad;
        logic       run;
    } vec_t;

    vec_t vecs[10];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    snake_body_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .step       (step),
        .dir_req    (dir_req),
        .apple_cord (apple_cord),
        .body       (body),
        .length     (length),
        .goodColl   (goodColl),
        .badColl    (badColl),
        .running    (running)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] d, input cord_t a, input cord_t h,
                                input cord_t t, input logic [5:0] l,
                                input logic g, input logic b, input logic r);
        vec_t v;
        v.dir = d; v.apple = a; v.head = h; v.tail = t;
        v.len = l; v.good = g; v.bad = b; v.run = r;
        return v;
    endfunction

    task automatic do_step();
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        cord_t e;

        // dir codes: 0 up, 1 right, 2 down, 3 left
        vecs[0] = mk(2'd1, 8'h00, 8'h65, 8'h45, 6'd3, 1'b0, 1'b0, 1'b1);
        vecs[1] = mk(2'd1, 8'h00, 8'h75, 8'h55, 6'd3, 1'b0, 1'b0, 1'b1);
        vecs[2] = mk(2'd1, 8'h00, 8'h85, 8'h65, 6'd3, 1'b0, 1'b0, 1'b1);
        vecs[3] = mk(2'd1, 8'h00, 8'h95, 8'h75, 6'd3, 1'b0, 1'b0, 1'b1);
        vecs[4] = mk(2'd1, 8'hA5, 8'hA5, 8'h75, 6'd4, 1'b1, 1'b0, 1'b1);
        vecs[5] = mk(2'd3, 8'h00, 8'hB5, 8'h85, 6'd4, 1'b0, 1'b0, 1'b1);
        vecs[6] = mk(2'd2, 8'hB6, 8'hB6, 8'h85, 6'd5, 1'b1, 1'b0, 1'b1);
        vecs[7] = mk(2'd3, 8'h00, 8'hA6, 8'h95, 6'd5, 1'b0, 1'b0, 1'b1);
        vecs[8] = mk(2'd0, 8'h00, 8'hA6, 8'h95, 6'd5, 1'b0, 1'b1, 1'b0);
        vecs[9] = mk(2'd0, 8'h00, 8'hA6, 8'h95, 6'd5, 1'b0, 1'b0, 1'b0);

        reset = 1'b0; start = 1'b0; step = 1'b0; dir_req = 2'd1; apple_cord = 8'h00;
        #12;
        chk("rst_head",  32'(body[0]), 32'h55);
        chk("rst_b1",    32'(body[1]), 32'h45);
        chk("rst_b2",    32'(body[2]), 32'h35);
        chk("rst_last",  32'(body[MAX_LEN-1]), 32'h35);
        chk("rst_len",   32'(length), 32'd3);
        chk("rst_good",  32'(goodColl), 32'd0);
        chk("rst_bad",   32'(badColl), 32'd0);
        chk("rst_run",   32'(running), 32'd0);

        @(negedge clk) reset = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_run",  32'(running), 32'd1);
        chk("start_head", 32'(body[0]), 32'h55);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dir_req    = vecs[i].dir;
            apple_cord = vecs[i].apple;
            chk("pulse_clr_good", 32'(goodColl), 32'd0);
            chk("pulse_clr_bad",  32'(badColl), 32'd0);
            @(negedge clk);
            step = 1'b1;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            step = 1'b0;
            v = exp_q.pop_front();
            chk($sformatf("v%0d_head", i), 32'(body[0]), 32'(v.head));
            chk($sformatf("v%0d_tail", i), 32'(body[MAX_LEN-1]), 32'(v.tail));
            chk($sformatf("v%0d_len",  i), 32'(length), 32'(v.len));
            chk($sformatf("v%0d_good", i), 32'(goodColl), 32'(v.good));
            chk($sformatf("v%0d_bad",  i), 32'(badColl), 32'(v.bad));
            chk($sformatf("v%0d_run",  i), 32'(running), 32'(v.run));
        end

        // DEAD -> IDLE (reinit) -> RUN while start is held
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        chk("reinit_run",  32'(running), 32'd0);
        chk("reinit_head", 32'(body[0]), 32'h55);
        chk("reinit_tail", 32'(body[MAX_LEN-1]), 32'h35);
        chk("reinit_len",  32'(length), 32'd3);
        @(negedge clk) start = 1'b0;
        chk("restart_run", 32'(running), 32'd1);

        // March right to the east wall, then one more step
        dir_req = 2'd1; apple_cord = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            do_step();
            e = 8'h55 + 8'(16 * k);
            chk($sformatf("wall_walk%0d", k), 32'(body[0]), 32'(e));
        end
        do_step();
`ifdef WRAP_WALLS_EN
        chk("wall_head", 32'(body[0]), 32'h05);
        chk("wall_bad",  32'(badColl), 32'd0);
        chk("wall_run",  32'(running), 32'd1);
`else
        chk("wall_head", 32'(body[0]), 32'hF5);
        chk("wall_bad",  32'(badColl), 32'd1);
        chk("wall_run",  32'(running), 32'd0);
`endif

        // start and step together in IDLE: start only
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) begin start = 1'b1; step = 1'b1; end
        @(negedge clk) begin start = 1'b0; step = 1'b0; end
        chk("ss_run",  32'(running), 32'd1);
        chk("ss_head", 32'(body[0]), 32'h55);
        chk("ss_len",  32'(length), 32'd3);
        do_step();
        chk("ss_move", 32'(body[0]), 32'h65);

        // reset lands between step sampling setup and the update edge
        @(negedge clk) step = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rmid_head", 32'(body[0]), 32'h55);
        chk("rmid_b1",   32'(body[1]), 32'h45);
        chk("rmid_len",  32'(length), 32'd3);
        chk("rmid_run",  32'(running), 32'd0);
        @(negedge clk) begin reset = 1'b1; step = 1'b0; end
        chk("rmid_after_head", 32'(body[0]), 32'h55);
        chk("rmid_after_run",  32'(running), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
